uart_fifo_mm: RTL and testbench

Memory-mapped buffered UART front-end between the uart core's byte streams and the CPU data bus (port B).
- RX FIFO captures bytes from the core's output stream.
- TX FIFO feeds bytes to the core's input stream.
- The CPU reads status and RX data, and writes TX data and control.
- Its port-B response plugs into the same read mux as the other memory-mapped peripherals, with one-cycle registered read latency.

---
 rtl/uart_fifo_defs.sv | 44 ++++
 rtl/sync_fifo_sa.sv | 67 ++++++
 rtl/uart_fifo_mm.sv | 147 ++++++++++++++
 tb/tb_uart_fifo_mm.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_defs.sv
// Shared register map and bit layout for the memory-mapped UART FIFO front-end.
package uart_fifo_defs;

    // Register offsets relative to the peripheral base address
    localparam int OFF_STATUS = 0;
    localparam int OFF_DATA   = 1;
    localparam int OFF_CTRL   = 2;

    // STATUS register bit positions
    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_NOTFULL   = 1;
    localparam int ST_RX_OVF       = 2;
    localparam int ST_TX_DROP      = 3;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    // CTRL register bit positions
    localparam int CTRL_FLUSH_RX    = 0;
    localparam int CTRL_FLUSH_TX    = 1;
    localparam int CTRL_CLEAR_FLAGS = 2;

    // DATA read: valid flag sits just above the returned byte
    localparam int DATA_VALID_BIT = 8;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_DATA,
        SEL_CTRL
    } reg_sel_t;

    // Map a bus address onto one of the three registers, or none
    function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        case (off)
            32'(OFF_STATUS): return SEL_STATUS;
            32'(OFF_DATA):   return SEL_DATA;
            32'(OFF_CTRL):   return SEL_CTRL;
            default:         return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO. dout always presents the oldest entry.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted
// only when a real pop happens in the same cycle. Flush overrides both.
module sync_fifo_sa #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO outright
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_mm.sv
// Memory-mapped buffered UART front-end: RX/TX FIFOs between the uart core
// byte streams and CPU port B, with STATUS/DATA/CTRL registers and a
// one-cycle registered read response for the shared peripheral read mux.
module uart_fifo_mm
    import uart_fifo_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int BASE  = 65541
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic [31:0] data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    reg_sel_t         sel;
    logic             is_write;
    logic             hit;
    logic             rd_status;
    logic             rd_data;
    logic             wr_data;
    logic             wr_ctrl;

    logic [7:0]       rx_dout;
    logic [CNT_W-1:0] rx_count;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_flush;

    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic             tx_flush;

    logic             rx_ovf;
    logic             tx_drop;
    logic             rx_ovf_set;
    logic             tx_drop_set;
    logic             flag_clear;

    logic [31:0]      read_value;
    logic             unused_bits;

    assign sel       = decode_addr(addr_b, 32'(BASE));
    assign is_write  = |data_b_we;
    assign hit       = (sel != SEL_NONE);
    assign rd_status = (sel == SEL_STATUS) && !is_write;
    assign rd_data   = (sel == SEL_DATA) && !is_write;
    assign wr_data   = (sel == SEL_DATA) && is_write;
    assign wr_ctrl   = (sel == SEL_CTRL) && is_write;

    // The receiver is never throttled; the ready simply tracks reset
    assign rx_tready = rst;
    assign rx_push   = rx_tvalid && rx_tready;
    assign rx_pop    = rd_data && !rx_empty;
    assign rx_flush  = wr_ctrl && data_b_in[CTRL_FLUSH_RX];

    assign tx_tvalid = !tx_empty;
    assign tx_pop    = tx_tvalid && tx_tready;
    assign tx_flush  = wr_ctrl && data_b_in[CTRL_FLUSH_TX];

    // A flush swallows any same-cycle push, so it must never flag a loss
    assign rx_ovf_set  = rx_push && rx_full && !rx_pop && !rx_flush;
    assign tx_drop_set = wr_data && tx_full && !tx_pop && !tx_flush;
    assign flag_clear  = wr_ctrl && data_b_in[CTRL_CLEAR_FLAGS];

    assign unused_bits = &{1'b0, data_b_in[31:8]};

    sync_fifo_sa #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_tdata),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo_sa #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (data_b_in[7:0]),
        .dout  (tx_tdata),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Read value for the current address, built from pre-update state
    always_comb begin
        read_value = '0;
        if (rd_status) begin
            read_value[ST_RX_NONEMPTY]              = !rx_empty;
            read_value[ST_TX_NOTFULL]               = !tx_full;
            read_value[ST_RX_OVF]                   = rx_ovf;
            read_value[ST_TX_DROP]                  = tx_drop;
            read_value[ST_RX_COUNT_LSB +: 8]        = 8'(rx_count);
            read_value[ST_TX_COUNT_LSB +: 8]        = 8'(tx_count);
        end else if (rd_data && !rx_empty) begin
            read_value[DATA_VALID_BIT]              = 1'b1;
            read_value[7:0]                         = rx_dout;
        end
    end

    // Sticky loss flags; a same-cycle set beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            rx_ovf  <= (rx_ovf  && !flag_clear) || rx_ovf_set;
            tx_drop <= (tx_drop && !flag_clear) || tx_drop_set;
        end
    end

    // Registered port-B response for the shared read mux
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_b   <= '0;
            strobe_b <= 1'b0;
        end else begin
            data_b   <= read_value;
            strobe_b <= hit;
        end
    end

endmodule

// File: tb/tb_uart_fifo_mm.sv
// Randomized plus directed bench for uart_fifo_mm against a queue-based model.
module tb_uart_fifo_mm;

    localparam int DEPTH = 16;
    localparam int BASE  = 65541;
    localparam logic [31:0] A_STATUS = 32'(BASE);
    localparam logic [31:0] A_DATA   = 32'(BASE + 1);
    localparam logic [31:0] A_CTRL   = 32'(BASE + 2);
    localparam logic [31:0] A_OTHER  = 32'(BASE + 3);

    logic        clk;
    logic        rst;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic [31:0] data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;

    int checkCount;
    int passCount;

    logic [7:0] rxQ[$];
    logic [7:0] txQ[$];
    logic       rxOvf;
    logic       txDrop;

    uart_fifo_mm #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .addr_b    (addr_b),
        .data_b_in (data_b_in),
        .data_b_we (data_b_we),
        .data_b    (data_b),
        .strobe_b  (strobe_b)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Asserts reset on whatever traffic is present, checks the cleared outputs, releases
    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_rx_tready", 32'(rx_tready), 32'h0);
        checkOutput("rst_tx_tvalid", 32'(tx_tvalid), 32'h0);
        checkOutput("rst_data_b", data_b, 32'h0);
        checkOutput("rst_strobe_b", 32'(strobe_b), 32'h0);
        rxQ.delete();
        txQ.delete();
        rxOvf  = 1'b0;
        txDrop = 1'b0;
        repeat (2) @(negedge clk);
        addr_b    = 32'h0;
        data_b_in = 32'h0;
        data_b_we = 32'h0;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h0;
        tx_tready = 1'b0;
        rst       = 1'b1;
    endtask

    // One bus/stream cycle: drive, check pre-edge streams, advance model, check response
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] we, input logic [31:0] wdata,
                                 input logic rxv, input logic [7:0] rxd, input logic txr);
        logic        hit;
        logic        isRd;
        logic        isWr;
        logic [31:0] expData;
        logic        ovfSet;
        logic        dropSet;
        logic        clr;
        @(negedge clk);
        addr_b    = addr;
        data_b_we = we;
        data_b_in = wdata;
        rx_tvalid = rxv;
        rx_tdata  = rxd;
        tx_tready = txr;
        #1;
        checkOutput("rx_tready", 32'(rx_tready), 32'h1);
        checkOutput("tx_tvalid", 32'(tx_tvalid), 32'(txQ.size() > 0));
        if (txQ.size() > 0) begin
            checkOutput("tx_tdata", 32'(tx_tdata), 32'(txQ[0]));
        end

        hit  = (addr == A_STATUS) || (addr == A_DATA) || (addr == A_CTRL);
        isRd = hit && (we == 32'h0);
        isWr = hit && (we != 32'h0);
        expData = 32'h0;
        if (isRd && addr == A_STATUS) begin
            expData = {8'h0, 8'(txQ.size()), 8'(rxQ.size()), 4'h0,
                       txDrop, rxOvf, 1'(txQ.size() < DEPTH), 1'(rxQ.size() > 0)};
        end else if (isRd && addr == A_DATA && rxQ.size() > 0) begin
            expData = 32'h100 | 32'(rxQ[0]);
        end

        ovfSet  = 1'b0;
        dropSet = 1'b0;
        clr     = isWr && addr == A_CTRL && wdata[2];

        if (isWr && addr == A_CTRL && wdata[0]) begin
            rxQ.delete();
        end else begin
            if (isRd && addr == A_DATA && rxQ.size() > 0) void'(rxQ.pop_front());
            if (rxv) begin
                if (rxQ.size() < DEPTH) rxQ.push_back(rxd);
                else ovfSet = 1'b1;
            end
        end

        if (isWr && addr == A_CTRL && wdata[1]) begin
            txQ.delete();
        end else begin
            if (txr && txQ.size() > 0) void'(txQ.pop_front());
            if (isWr && addr == A_DATA) begin
                if (txQ.size() < DEPTH) txQ.push_back(wdata[7:0]);
                else dropSet = 1'b1;
            end
        end

        rxOvf  = (rxOvf  && !clr) || ovfSet;
        txDrop = (txDrop && !clr) || dropSet;

        @(posedge clk);
        #1;
        checkOutput("strobe_b", 32'(strobe_b), 32'(hit));
        checkOutput("data_b", data_b, expData);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rxOvf      = 1'b0;
        txDrop     = 1'b0;
        rst        = 1'b0;
        addr_b     = 32'h0;
        data_b_in  = 32'h0;
        data_b_we  = 32'h0;
        rx_tvalid  = 1'b0;
        rx_tdata   = 8'h0;
        tx_tready  = 1'b0;
        doReset();

        // Reset mid-traffic, then STATUS reads back only tx_notfull
        applyStimulus(A_DATA, 32'h1, 32'h33, 1'b1, 8'h11, 1'b0);
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b1, 8'h12, 1'b0);
        doReset();
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p1_status", data_b, 32'h0000_0002);
        checkOutput("p1_strobe", 32'(strobe_b), 32'h1);
        checkOutput("p1_tx_tvalid", 32'(tx_tvalid), 32'h0);

        // RX basic
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b1, 8'h41, 1'b0);
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b1, 8'h42, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p2_status", data_b, 32'h0000_0203);
        applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p2_rd0", data_b, 32'h141);
        applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p2_rd1", data_b, 32'h142);
        applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p2_rd_empty", data_b, 32'h000);
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p2_status_end", data_b, 32'h0000_0002);

        // RX overflow
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b1, 8'(i), 1'b0);
        end
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p3_status", data_b, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
            checkOutput("p3_rd", data_b, 32'h100 + 32'(i));
        end
        applyStimulus(A_CTRL, 32'h1, 32'h4, 1'b0, 8'h0, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p3_status_clr", data_b, 32'h0000_0002);

        // TX with backpressure
        applyStimulus(A_DATA, 32'h1, 32'h55, 1'b0, 8'h0, 1'b0);
        applyStimulus(A_DATA, 32'h1, 32'hAA, 1'b0, 8'h0, 1'b0);
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p4_tvalid", 32'(tx_tvalid), 32'h1);
        checkOutput("p4_hold", 32'(tx_tdata), 32'h55);
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1);
        checkOutput("p4_second", 32'(tx_tdata), 32'hAA);
        applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1);
        checkOutput("p4_drained", 32'(tx_tvalid), 32'h0);

        // TX full
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(A_DATA, 32'h1, 32'(i), 1'b0, 8'h0, 1'b0);
        end
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p5_status", data_b, 32'h0010_0008);
        for (int i = 0; i < 16; i++) begin
            checkOutput("p5_order", 32'(tx_tdata), 32'(i));
            applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1);
        end
        checkOutput("p5_drained", 32'(tx_tvalid), 32'h0);
        applyStimulus(A_CTRL, 32'h1, 32'h4, 1'b0, 8'h0, 1'b0);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            applyStimulus(A_OTHER, 32'h0, 32'h0, 1'b1, 8'h20 + 8'(i), 1'b0);
        end
        applyStimulus(A_DATA, 32'h0, 32'h0, 1'b1, 8'h99, 1'b0);
        checkOutput("p6_oldest", data_b, 32'h120);
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p6_status", data_b, 32'h0000_1003);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
            checkOutput("p6_rd", data_b, 32'h120 + 32'(i));
        end
        applyStimulus(A_DATA, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p6_newest", data_b, 32'h199);

        // Flush both concurrent with an RX push
        applyStimulus(A_DATA, 32'h1, 32'h61, 1'b1, 8'h71, 1'b0);
        applyStimulus(A_DATA, 32'h1, 32'h62, 1'b1, 8'h72, 1'b0);
        applyStimulus(A_CTRL, 32'h1, 32'h3, 1'b1, 8'h77, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0);
        checkOutput("p6_flush", data_b, 32'h0000_0002);
        checkOutput("p6_flush_tx", 32'(tx_tvalid), 32'h0);

        // Randomized traffic, with one reset dropped in the middle
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] addr;
            logic [31:0] we;
            logic [31:0] wdata;
            case ($urandom_range(0, 3))
                0:       addr = A_STATUS;
                1:       addr = A_DATA;
                2:       addr = A_CTRL;
                default: addr = ($urandom_range(0, 1) == 0) ? A_OTHER : 32'($urandom);
            endcase
            we    = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            wdata = 32'($urandom);
            if (addr == A_CTRL && $urandom_range(0, 5) != 0) wdata[1:0] = 2'b00;
            applyStimulus(addr, we, wdata, 1'($urandom_range(0, 9) < 6), 8'($urandom),
                          1'($urandom_range(0, 9) < 3));
            if (n == 1500) doReset();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
